instr_fetch_queue: RTL

- Fetch stage directly downstream of the program counter register.
- Takes the current PC and issues one word fetch at a time to instruction memory over a req/ack handshake.
- Queues returned {pc, instruction} pairs in a small FIFO for the decode stage.
- Back-pressures the PC through stall_out and handles branch redirects by flushing, including discarding a fetch already in flight.

---
 rtl/instr_fetch_queue.sv | 122 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues one word fetch at a time over req/ack and
// queues {pc, instr} pairs for decode. Branch redirects flush the queue and any in-flight fetch.
module instr_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        stall_out,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        id_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     addr_q;
  logic [31:0]     addr_cur;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic            push;
  logic            pop;
  logic            latch;

  assign addr_cur  = (state == S_IDLE) ? pc_in : addr_q;
  assign imem_addr = {addr_cur[31:2], 2'b00};

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    stall_out  = 1'b1;
    push       = 1'b0;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        imem_req = (count < FULL) & ~flush;
        if (imem_req & imem_ack) begin
          push      = 1'b1;
          stall_out = 1'b0;
        end else if (imem_req) begin
          latch      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        imem_req = 1'b1;
        // A flush abandons the pending response: drop it now or wait it out in DRAIN.
        if (flush) begin
          state_next = imem_ack ? S_IDLE : S_DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          stall_out  = 1'b0;
          state_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        imem_req = 1'b1;
        if (imem_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) stall_out = 1'b0;
    if (reset) begin
      imem_req  = 1'b0;
      stall_out = 1'b0;
    end
  end

  assign if_valid    = (count != '0);
  assign pop         = if_valid & id_ready & ~flush;
  assign if_pc       = if_valid ? q_pc[rd_ptr]    : '0;
  assign if_instr    = if_valid ? q_instr[rd_ptr] : '0;
  assign if_pc_plus4 = if_valid ? (q_pc[rd_ptr] + 32'd4) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      addr_q <= '0;
    end else begin
      state <= state_next;
      if (latch) addr_q <= imem_addr;
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q_pc[wr_ptr]    <= imem_addr;
          q_instr[wr_ptr] <= imem_rdata;
          wr_ptr          <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (push & ~pop)      count <= count + CW'(1);
        else if (pop & ~push) count <= count - CW'(1);
      end
    end
  end

endmodule
